// File: rtl/z80_block_xfer_pkg.sv
// Shared Z80 flag bit positions/masks and the block-transfer FSM state encoding.
// The optional LDIR/LDDR looping is enabled by defining Z80_BLOCK_REPEAT_EN.
package z80_block_xfer_pkg;

   localparam int FLAG_C_BIT  = 0;
   localparam int FLAG_N_BIT  = 1;
   localparam int FLAG_PV_BIT = 2;
   localparam int FLAG_X3_BIT = 3;
   localparam int FLAG_H_BIT  = 4;
   localparam int FLAG_X5_BIT = 5;
   localparam int FLAG_Z_BIT  = 6;
   localparam int FLAG_S_BIT  = 7;

   localparam logic [7:0] FLAG_C_MASK  = 8'h01;
   localparam logic [7:0] FLAG_N_MASK  = 8'h02;
   localparam logic [7:0] FLAG_PV_MASK = 8'h04;
   localparam logic [7:0] FLAG_H_MASK  = 8'h10;
   localparam logic [7:0] FLAG_Z_MASK  = 8'h40;
   localparam logic [7:0] FLAG_S_MASK  = 8'h80;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_e;

   // LDI/LDD flag result: H and N cleared, PV reports a non-zero BC, the rest untouched.
   function automatic logic [7:0] ldx_flags(input logic [7:0] f, input logic pv);
      return (f & ~(FLAG_H_MASK | FLAG_N_MASK | FLAG_PV_MASK)) | (pv ? FLAG_PV_MASK : 8'h00);
   endfunction

endpackage

// File: rtl/z80_block_xfer_if.sv
// Decoder-side request/result signals and memory bus of the block-transfer engine.
// Bus handshake: mem_rd/mem_wr hold with stable address/data until a cycle with mem_ready=1 completes them.
interface z80_block_xfer_if #(parameter int ADDR_W = 16);
   logic              start;
   logic              dir_dec;
   logic              repeat_en;
   logic [ADDR_W-1:0] bc_in;
   logic [ADDR_W-1:0] de_in;
   logic [ADDR_W-1:0] hl_in;
   logic [7:0]        f_in;
   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              mem_ready;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] bc_out;
   logic [ADDR_W-1:0] de_out;
   logic [ADDR_W-1:0] hl_out;
   logic [7:0]        f_out;

   modport master (
      input  start, dir_dec, repeat_en, bc_in, de_in, hl_in, f_in, mem_rdata, mem_ready,
      output mem_rd, mem_wr, mem_addr, mem_wdata, busy, done, bc_out, de_out, hl_out, f_out
   );

   modport slave (
      output start, dir_dec, repeat_en, bc_in, de_in, hl_in, f_in, mem_rdata, mem_ready,
      input  mem_rd, mem_wr, mem_addr, mem_wdata, busy, done, bc_out, de_out, hl_out, f_out
   );
endinterface

// File: rtl/z80_block_xfer_regs.sv
// BC/DE/HL/F working registers of the block-transfer engine with the per-iteration
// decrement/step and flag update.
module z80_block_xfer_regs
   import z80_block_xfer_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic              step_i,
   input  logic              dir_dec_i,
   input  logic [ADDR_W-1:0] bc_i,
   input  logic [ADDR_W-1:0] de_i,
   input  logic [ADDR_W-1:0] hl_i,
   input  logic [7:0]        f_i,
   output logic [ADDR_W-1:0] bc_o,
   output logic [ADDR_W-1:0] de_o,
   output logic [ADDR_W-1:0] hl_o,
   output logic [ADDR_W-1:0] hl_next_o,
   output logic [7:0]        f_o,
   output logic              bc_next_nz_o
);
   logic [ADDR_W-1:0] bc_q, bc_d, de_q, de_d, hl_q, hl_d;
   logic [7:0]        f_q, f_d;
   logic              dir_q;
   logic              bc_nz;

   always_comb begin
      bc_d  = bc_q - ADDR_W'(1);
      de_d  = dir_q ? de_q - ADDR_W'(1) : de_q + ADDR_W'(1);
      hl_d  = dir_q ? hl_q - ADDR_W'(1) : hl_q + ADDR_W'(1);
      bc_nz = (bc_d != '0);
      f_d   = ldx_flags(f_q, bc_nz);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bc_q  <= '0;
         de_q  <= '0;
         hl_q  <= '0;
         f_q   <= '0;
         dir_q <= 1'b0;
      end else if (load_i) begin
         bc_q  <= bc_i;
         de_q  <= de_i;
         hl_q  <= hl_i;
         f_q   <= f_i;
         dir_q <= dir_dec_i;
      end else if (step_i) begin
         bc_q <= bc_d;
         de_q <= de_d;
         hl_q <= hl_d;
         f_q  <= f_d;
      end
   end

   assign bc_o         = bc_q;
   assign de_o         = de_q;
   assign hl_o         = hl_q;
   assign hl_next_o    = hl_d;
   assign f_o          = f_q;
   assign bc_next_nz_o = bc_nz;
endmodule

// File: rtl/z80_block_xfer.sv
// Z80 LDI/LDD block-transfer engine: read at HL, write at DE, then update BC/DE/HL/F.
// Define Z80_BLOCK_REPEAT_EN to honour repeat_en (LDIR/LDDR looping until BC reaches 0).
module z80_block_xfer
   import z80_block_xfer_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic          clk,
   input  logic          reset,
   z80_block_xfer_if.master bus,
   output state_e        state_dbg_o
);
`ifdef Z80_BLOCK_REPEAT_EN
   localparam logic REPEAT_ALLOWED = 1'b1;
`else
   localparam logic REPEAT_ALLOWED = 1'b0;
`endif

   state_e            state_q;
   logic              mem_rd_q, mem_wr_q, busy_q, done_q, rep_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [7:0]        mem_wdata_q;
   logic [ADDR_W-1:0] bc_w, de_w, hl_w, hl_next_w;
   logic [7:0]        f_w;
   logic              bc_next_nz, load, step, loop_go;

   assign load    = (state_q == ST_IDLE) && bus.start;
   assign step    = (state_q == ST_WRITE) && bus.mem_ready;
   assign loop_go = rep_q && bc_next_nz;

   z80_block_xfer_regs #(.ADDR_W(ADDR_W)) u_regs (
      .clk          (clk),
      .reset        (reset),
      .load_i       (load),
      .step_i       (step),
      .dir_dec_i    (bus.dir_dec),
      .bc_i         (bus.bc_in),
      .de_i         (bus.de_in),
      .hl_i         (bus.hl_in),
      .f_i          (bus.f_in),
      .bc_o         (bc_w),
      .de_o         (de_w),
      .hl_o         (hl_w),
      .hl_next_o    (hl_next_w),
      .f_o          (f_w),
      .bc_next_nz_o (bc_next_nz)
   );

   // mem_wdata_q doubles as the read-data latch between READ and WRITE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rep_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q    <= ST_READ;
                  mem_rd_q   <= 1'b1;
                  busy_q     <= 1'b1;
                  mem_addr_q <= bus.hl_in;
                  rep_q      <= bus.repeat_en && REPEAT_ALLOWED;
               end
            end
            ST_READ: begin
               if (bus.mem_ready) begin
                  state_q     <= ST_WRITE;
                  mem_rd_q    <= 1'b0;
                  mem_wr_q    <= 1'b1;
                  mem_addr_q  <= de_w;
                  mem_wdata_q <= bus.mem_rdata;
               end
            end
            ST_WRITE: begin
               if (bus.mem_ready) begin
                  mem_wr_q <= 1'b0;
                  if (loop_go) begin
                     state_q    <= ST_READ;
                     mem_rd_q   <= 1'b1;
                     mem_addr_q <= hl_next_w;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.mem_rd    = mem_rd_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.bc_out    = bc_w;
   assign bus.de_out    = de_w;
   assign bus.hl_out    = hl_w;
   assign bus.f_out     = f_w;
   assign state_dbg_o   = state_q;
endmodule

// File: doc/z80_block_xfer.md
Name: z80_block_xfer

Overview:
- Sequential execution engine for the Z80 block-transfer group.
- Covers LDI (ascending, HL/DE increment) and its opposite-direction twin LDD (descending, HL/DE decrement).
- Performs the memory read at HL, then the write at DE, over a ready-handshaked memory port, and returns updated BC/DE/HL/F.
- Sits between the instruction decoder and the memory bus controller. Results must match the formal insn specs for LDI/LDD exactly.

Parameters:
- ADDR_W, 16, address and register-pair width (fixed at 16 for Z80; exposed for bench sizing only).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- dir_dec  in  1  0 = LDI (HL/DE increment), 1 = LDD (HL/DE decrement)
- repeat_en  in  1  1 = LDIR/LDDR looping (honoured only with the optional feature)
- bc_in, de_in, hl_in  in  16  register pairs, captured at start
- f_in  in  8  flags, captured at start
- mem_rd  out  1  read request
- mem_wr  out  1  write request
- mem_addr  out  16  bus address
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid when mem_ready=1 during a read
- mem_ready  in  1  completes the current mem_rd/mem_wr cycle
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when results are final
- bc_out, de_out, hl_out  out  16  working register pairs
- f_out  out  8  working flags

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE; mem_rd=mem_wr=busy=done=0; mem_addr=mem_wdata=0; bc/de/hl_out=0; f_out=0.
- States: IDLE -> READ -> WRITE -> IDLE.
  - IDLE: on start=1, latch bc/de/hl/f inputs, dir_dec and repeat_en; go to READ next cycle. start=0 holds IDLE.
  - READ: mem_rd=1, mem_addr=hl_out. Hold until mem_ready=1. On that cycle capture mem_rdata into the data latch and go to WRITE.
  - WRITE: mem_wr=1, mem_addr=de_out, mem_wdata=latch. Hold until mem_ready=1. On that edge apply the register and flag updates below.
- Register and flag updates, applied at the end of WRITE:
  - bc_out=bc-1.
  - hl_out/de_out = +1 (dir_dec=0) or -1 (dir_dec=1). All arithmetic is mod 2^16.
  - f_out: H=0 and N=0; PV = (bc_new != 0); S, Z, C, bit3 and bit5 are preserved.
  - Then: if looping applies (see Optional Feature) and bc_new != 0, go to READ; else assert done for one cycle and go to IDLE.
- Bus outputs: mem_rd and mem_wr are never both high. Both drop the cycle after the completing mem_ready.
- Latency: with mem_ready held at 1, start is sampled at edge 0; READ occupies cycle 1, WRITE cycle 2, and done=1 in cycle 3 together with the final outputs.
- Each wait-state cycle adds exactly one cycle.
- Outputs: bc/de/hl/f_out hold their last values in IDLE until the next start.
- Boundaries:
  - bc_in=0 decrements to FFFF, so PV=1. With looping, this runs 65536 iterations.
  - hl/de: FFFF+1 -> 0000 and 0000-1 -> FFFF.
  - bc_in=1: PV=0 and the loop terminates.
  - start while busy: ignored, with no state change.
  - mem_ready while neither mem_rd nor mem_wr is asserted: ignored.
  - reset in READ or WRITE: mem_rd/mem_wr drop the next cycle, state returns to IDLE, no done pulse, partial results discarded.

Optional Feature:
- Macro: Z80_BLOCK_REPEAT_EN.
- Defined: repeat_en=1 loops READ->WRITE until bc_new==0. done pulses once, at the end of the last iteration. Intermediate register values are visible on the outputs after each WRITE.
- Undefined: repeat_en is ignored. Every start performs exactly one transfer. The port remains present.

Decomposition:
- Shared header/package: the flag bit constants and masks (S, Z, H, PV, N, C bit positions) and the state encoding IDLE/READ/WRITE. These go alongside the existing z80 flag definitions.
- One natural sub-module, z80_block_xfer_regs: holds the BC/DE/HL/F working registers and the inc/dec/flag update logic. The top level keeps the FSM and bus handshake.

Test Plan:
- LDI, ready=1: HL=1000, DE=2000, BC=0003, F=FF, mem[1000]=5A -> write 5A@2000. Outputs HL=1001, DE=2001, BC=0002, F=ED (H, N cleared, PV set). done in cycle 3.
- LDD wrap: HL=0000, DE=0000, BC=0001, F=00, mem[0000]=A5 -> write A5@0000. Outputs HL=FFFF, DE=FFFF, BC=0000, F=00 (PV=0).
- Wait states: ready low for 2 cycles in READ and 1 cycle in WRITE -> mem_rd held 3 cycles and mem_wr held 2 cycles. done in cycle 6. Address and data stable throughout.
- BC=0000, LDI, repeat_en=0 -> BC=FFFF, PV=1, single transfer.
- With Z80_BLOCK_REPEAT_EN, LDIR: HL=0100, DE=0200, BC=0003 -> three read/write pairs (0100->0200, 0101->0201, 0102->0202). Final HL=0103, DE=0203, BC=0000, PV=0, single done pulse.
- Reset asserted during WRITE with mem_ready=0 -> next cycle mem_wr=0, busy=0, no done pulse. A following start executes normally.
